// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: fixed-priority A/B arbiter with starvation guard in front of the OTTER data port
module otter_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        MEM_CLK,
    input  logic        MEM_RST_N,
    input  logic        A_REQ,
    input  logic        A_WE,
    input  logic [31:0] A_ADDR,
    input  logic [31:0] A_DIN,
    input  logic [1:0]  A_SIZE,
    input  logic        A_SIGN,
    input  logic        B_REQ,
    input  logic        B_WE,
    input  logic [31:0] B_ADDR,
    input  logic [31:0] B_DIN,
    input  logic [1:0]  B_SIZE,
    input  logic        B_SIGN,
    output logic        A_GNT,
    output logic        B_GNT,
    output logic        A_RVALID,
    output logic        B_RVALID,
    output logic [31:0] A_DOUT,
    output logic [31:0] B_DOUT,
    output logic        M_RDEN2,
    output logic        M_WE2,
    output logic [31:0] M_ADDR2,
    output logic [31:0] M_DIN2,
    output logic [1:0]  M_SIZE,
    output logic        M_SIGN,
    input  logic [31:0] M_DOUT2
);
    typedef enum logic [1:0] {IDLE, ACC_A, ACC_B} state_t;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        we_q, sign_q, a_rvalid_q, b_rvalid_q, starved;
    logic [1:0]  size_q;
    logic [31:0] addr_q, din_q, a_dout_q, b_dout_q;
    assign starved = starve_q == LIMIT;
    assign A_GNT = A_REQ & ~(B_REQ & starved);
    assign B_GNT = B_REQ & ~A_GNT;
    always_comb begin
        state_d  = A_GNT ? ACC_A : B_GNT ? ACC_B : IDLE;
        starve_d = (!B_REQ || B_GNT) ? 4'd0 : (A_GNT && !starved) ? starve_q + 4'd1 : starve_q;
    end
    // Command fields hold through IDLE so the memory sees stable address/size lines.
    always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
        if (!MEM_RST_N) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_dout_q   <= '0;
            b_dout_q   <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            if (A_GNT || B_GNT) begin
                we_q   <= B_GNT ? B_WE : A_WE;
                addr_q <= B_GNT ? B_ADDR : A_ADDR;
                din_q  <= B_GNT ? B_DIN : A_DIN;
                size_q <= B_GNT ? B_SIZE : A_SIZE;
                sign_q <= B_GNT ? B_SIGN : A_SIGN;
            end
            a_rvalid_q <= state_q == ACC_A && !we_q;
            b_rvalid_q <= state_q == ACC_B && !we_q;
            if (state_q == ACC_A && !we_q) a_dout_q <= M_DOUT2;
            if (state_q == ACC_B && !we_q) b_dout_q <= M_DOUT2;
        end
    end
    assign M_RDEN2  = state_q != IDLE && !we_q;
    assign M_WE2    = state_q != IDLE && we_q;
    assign M_ADDR2  = addr_q;
    assign M_DIN2   = din_q;
    assign M_SIZE   = size_q;
    assign M_SIGN   = sign_q;
    assign A_RVALID = a_rvalid_q;
    assign B_RVALID = b_rvalid_q;
    assign A_DOUT   = a_dout_q;
    assign B_DOUT   = b_dout_q;
endmodule

// File: doc/otter_mem_arbiter.md
# otter_mem_arbiter

Two-requester arbiter that shares the OTTER memory's data port (port 2) between the CPU load/store unit (requester A) and a secondary bus master such as a DMA or debug loader (requester B). It sits between both masters and the memory, registers each granted command, drives the memory's synchronous negedge-read port for exactly one cycle per access, and returns sized read data to the winning requester. Instruction port 1 is not touched. A has fixed priority, and a starvation counter guarantees B progress.

## Interface
- STARVE_LIMIT, default 4: max consecutive A grants while B_REQ is pending before B is forced; range 1–15.
- MEM_CLK  in  1  clock; all arbiter state on rising edge.
- MEM_RST_N  in  1  reset, asynchronous and active-low.
- A_REQ, B_REQ  in  1  request; held with its command fields until the matching GNT is seen.
- A_WE, B_WE  in  1  1 = store, 0 = load.
- A_ADDR, B_ADDR  in  32  byte address.
- A_DIN, B_DIN  in  32  store data.
- A_SIZE, B_SIZE  in  2  0 = byte, 1 = half, 2 = word.
- A_SIGN, B_SIGN  in  1  1 = unsigned, 0 = signed.
- A_GNT, B_GNT  out  1  combinational; high in the cycle the request is accepted.
- A_RVALID, B_RVALID  out  1  one-cycle pulse; load data valid.
- A_DOUT, B_DOUT  out  32  registered load data; holds its value until the next RVALID for that port.
- M_RDEN2, M_WE2  out  1  memory read / write enable.
- M_ADDR2, M_DIN2  out  32  memory address / store data.
- M_SIZE  out  2  memory size.
- M_SIGN  out  1  memory sign.
- M_DOUT2  in  32  sized memory read data, valid after the negedge of the access cycle.

## Operation
- Per-cycle selection (combinational):
  - no REQ: no grant.
  - only one REQ: grant it.
  - both REQ: grant A unless starve_cnt == STARVE_LIMIT, then grant B.
- Only one GNT is ever high.
- On the rising edge that ends a grant cycle, a command register loads {owner, WE, ADDR, DIN, SIZE, SIGN} and sets cmd_valid.
- If there is no grant, cmd_valid clears.
- State (cmd_valid, owner) takes three values:
  - IDLE: cmd_valid = 0.
  - ACC_A: cmd_valid = 1, owner = A.
  - ACC_B: cmd_valid = 1, owner = B.
- Any state moves to ACC_A, ACC_B or IDLE according to that cycle's grant. Back-to-back accesses are allowed in every combination.
- In ACC_x, M_* outputs are driven from the command register:
  - M_RDEN2 = ~WE.
  - M_WE2 = WE.
- In IDLE, M_RDEN2 = M_WE2 = 0. M_ADDR2, M_DIN2, M_SIZE and M_SIGN hold their last values.
- Load completion: at the rising edge ending ACC_x with WE = 0, x_DOUT <= M_DOUT2 and x_RVALID = 1 for the next cycle.
- Stores produce no RVALID; a store is complete once granted.
- starve_cnt (4 bit):
  - increments on each A grant while B_REQ = 1.
  - clears on a B grant or whenever B_REQ = 0.
  - saturates at STARVE_LIMIT.
- Addresses ≥ 0x0001_0000 (MMIO) are arbitrated identically; the memory handles IO decode.
- Requesters must not change fields while REQ is high and GNT is low. Dropping REQ before GNT withdraws the request.

## Timing
- Load latency: GNT in cycle c → memory access in cycle c+1 (negedge capture) → RVALID and DOUT in cycle c+2.
- Throughput: one access per cycle. Pipelined loads return RVALID on consecutive cycles, in grant order.
- M_SIZE and M_SIGN are stable for the whole access cycle, because the memory sizes data combinationally from them.
- Simultaneous RVALID for a previous load and GNT for a new request is legal.
- Simultaneous A and B requests with starve_cnt < STARVE_LIMIT: A wins and starve_cnt increments.
- Reset values: all GNT and RVALID = 0; M_RDEN2 = M_WE2 = 0; M_ADDR2, M_DIN2, M_SIZE, M_SIGN = 0; A_DOUT = B_DOUT = 0; state IDLE; starve_cnt = 0.
- Reset asserted mid-access: the in-flight access is abandoned and no RVALID is issued. A store whose negedge has already passed stays committed; otherwise it is lost.
- After deassertion, the first grant is possible in the first cycle.

## Test plan
- Single A load, A_ADDR = 0x100, SIZE = 2, memory word 0xDEADBEEF → A_GNT in cycle 0, M_RDEN2 = 1 in cycle 1, A_RVALID = 1 and A_DOUT = 0xDEADBEEF in cycle 2; B outputs stay 0.
- A and B both requesting continuously with STARVE_LIMIT = 4 → grant pattern A,A,A,A,B repeating; starve_cnt reads 0,1,2,3,4,0.
- B store of byte 0x5A to 0x203 (SIZE = 0), followed by an A load byte from 0x203 (SIZE = 0, SIGN = 1) on the next cycle → A_DOUT = 0x0000005A with A_RVALID two cycles after A_GNT.
- Back-to-back A loads from 0x0, 0x4, 0x8 → three consecutive A_RVALID pulses, data returned in order.
- MEM_RST_N pulled low during ACC_A (load) → no A_RVALID; all outputs return to the reset values above; a new request after release is granted in the first cycle.
- B_REQ raised then dropped before any grant while A is busy → B never granted; starve_cnt returns to 0.
